// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_pkg
// Brief    : Shared types and constants for the run/pause/lap count controller.
// Revision : 1.0
// ============================================================================
package count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam int CLK_50        = 50_000_000;
    localparam int DEBOUNCE_20MS = CLK_50 / 50;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer, stability counter and press-event pulse.
// Revision : 1.0
// ============================================================================
module btn_debounce
    import count_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_20MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int              c_cnt_w    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_differ;
    logic               w_settled;

    assign w_differ  = (r_sync1 != r_level);
    assign w_settled = w_differ && (r_cnt == c_cnt_last);

    // The press pulse coincides with the edge that loads the new debounced
    // level, so the consumer acts in the same cycle the level settles.
    assign o_press = w_settled && !r_sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btn_n;
            r_sync1 <= r_sync0;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_run_ctrl
// Brief    : Run/pause/lap controller and tick generator for a BCD counter.
// Revision : 1.0
// ============================================================================
module count_run_ctrl
    import count_pkg::*;
#(
    parameter int CLK_HZ       = CLK_50,
    parameter int TICK_HZ      = 1,
    parameter int DEBOUNCE_CYC = DEBOUNCE_20MS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_n,
    input  logic       btn_lap_n,
    input  logic       btn_clr_n,
    input  logic       sw_dir,
    input  logic       sw_fast,
    input  logic       cnt_zero,
    input  logic       cnt_max,
    output logic       tick,
    output logic       dir,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
);

    localparam int              c_div       = CLK_HZ / TICK_HZ;
    localparam int              c_pre_w     = $clog2(c_div) + 1;
    localparam logic [c_pre_w-1:0] c_term_slow = c_pre_w'(c_div - 1);
    localparam logic [c_pre_w-1:0] c_term_fast = c_pre_w'(CLK_HZ / (2 * TICK_HZ) - 1);

    logic               w_start_ev;
    logic               w_lap_ev;
    logic               w_clr_ev;
    logic [c_pre_w-1:0] w_term;
    logic               w_due;
    logic               w_stop;

    run_state_t         r_state;
    logic [c_pre_w-1:0] r_pre;
    logic               r_tick;
    logic               r_dir;
    logic               r_clr;
    logic               r_hold;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (btn_start_n),
        .o_press (w_start_ev)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (btn_lap_n),
        .o_press (w_lap_ev)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (btn_clr_n),
        .o_press (w_clr_ev)
    );

    // Rate switch takes effect at once; >= catches a prescaler already past it.
    assign w_term = sw_fast ? c_term_fast : c_term_slow;
    assign w_due  = (r_pre >= w_term);
    assign w_stop = w_due && (r_dir ? cnt_zero : cnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_dir   <= 1'b0;
            r_clr   <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_clr  <= 1'b0;
            if (w_clr_ev) begin
                r_state <= IDLE;
                r_clr   <= 1'b1;
                r_hold  <= 1'b0;
                r_dir   <= sw_dir;
                r_pre   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_dir <= sw_dir;
                        if (w_start_ev) begin
                            r_state <= RUN;
                            r_pre   <= '0;
                        end
                    end
                    RUN: begin
                        if (w_stop) begin
                            r_state <= DONE;
                            r_pre   <= '0;
                        end else if (w_start_ev) begin
                            // Prescaler frozen so resume continues the period.
                            r_state <= PAUSE;
                        end else begin
                            if (w_due) begin
                                r_pre  <= '0;
                                r_tick <= 1'b1;
                            end else begin
                                r_pre <= r_pre + 1'b1;
                            end
                            if (w_lap_ev) begin
                                r_hold <= ~r_hold;
                            end
                        end
                    end
                    PAUSE: begin
                        if (w_start_ev) begin
                            r_state <= RUN;
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tick  = r_tick;
    assign dir   = r_dir;
    assign clr   = r_clr;
    assign hold  = r_hold;
    assign state = r_state;

endmodule
`default_nettype wire

// File: doc/count_run_ctrl.md
Name: count_run_ctrl

Overview:
Run/pause/lap controller for the 4-digit BCD counter datapath on the DE2 board. Debounces KEY[3:1] and generates the count-enable tick at 1x or 2x rate. Owns count direction, clear and display-freeze (lap). Detects terminal count (9999 up, 0000 down) and stops there instead of wrapping. The counter datapath becomes a pure tick-driven BCD chain.

Parameters:
CLK_HZ, 50_000_000, input clock frequency.
TICK_HZ, 1, nominal count rate in 1x mode; 2x mode uses half the period.
DEBOUNCE_CYC, 1_000_000, cycles a raw button level must stay stable before it is accepted (20 ms at 50 MHz).

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low; driven from KEY[0].
btn_start_n  input  1  raw KEY[1], active-low, asynchronous to clk; start/pause toggle.
btn_lap_n  input  1  raw KEY[2], active-low; lap (freeze display) toggle.
btn_clr_n  input  1  raw KEY[3], active-low; clear.
sw_dir  input  1  0 = count up, 1 = count down (sw[0]).
sw_fast  input  1  1 = 2x rate (sw[1]).
cnt_zero  input  1  datapath reports value 0000.
cnt_max  input  1  datapath reports value 9999.
tick  output  1  one-cycle count-enable pulse to the datapath.
dir  output  1  latched direction to the datapath.
clr  output  1  one-cycle synchronous clear to the datapath (load 0000 up / 9999 down).
hold  output  1  1 = display registers frozen (lap).
state  output  2  current FSM state, for LED debug.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tick=0, clr=0, hold=0, dir=0; prescaler=0; debounced levels=1; sync flops=1.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a debounce counter.
  - The counter resets on any mismatch between the synced level and the debounced level.
  - When it reaches DEBOUNCE_CYC-1, the debounced level takes the synced level.
  - Press event = debounced 1->0 transition, one-cycle pulse.
  - Latency raw press -> event = 2 + DEBOUNCE_CYC cycles. Releases generate no event.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - IDLE + start event -> RUN. Latch dir<=sw_dir, prescaler<=0.
  - RUN + start event -> PAUSE. Prescaler holds its value.
  - PAUSE + start event -> RUN. Prescaler resumes from the held value.
  - RUN + terminal condition -> DONE (see tick rules).
  - DONE + start event -> no effect.
  - Any state + clr event -> IDLE, with clr=1 for exactly one cycle and hold<=0.
- Same-cycle precedence: clr event > terminal > start event > lap event.
- sw_dir changes are ignored outside IDLE. While in IDLE, dir tracks sw_dir every cycle so a clear loads the correct start value.
- Tick generation (RUN only):
  - TERM = CLK_HZ/TICK_HZ-1, or CLK_HZ/(2*TICK_HZ)-1 when sw_fast=1.
  - Each cycle: if prescaler >= TERM, prescaler<=0 and a tick is due; otherwise prescaler+1.
  - A sw_fast change mid-period applies immediately. If prescaler is already >= the new TERM, the tick is due on the next cycle.
  - Due tick with dir=0 and cnt_max=1: tick stays 0 and FSM -> DONE (no wrap).
  - Due tick with dir=1 and cnt_zero=1: tick stays 0 and FSM -> DONE.
  - Otherwise tick=1 for one cycle.
  - tick is never asserted outside RUN, and never in the cycle clr=1.
- Lap: a lap event in RUN toggles hold. It is ignored in IDLE, PAUSE and DONE. hold stays 1 across RUN<->PAUSE.
- Prescaler width: $clog2(CLK_HZ/TICK_HZ)+1 bits, unsigned; comparisons are unsigned.
- Reset mid-debounce or mid-run drops everything to the reset values; no pulse is emitted on reset release.

Decomposition:
- Package count_pkg holds:
  - typedef enum logic [1:0] run_state_t {IDLE, RUN, PAUSE, DONE};
  - localparam CLK_50 = 50_000_000;
  - localparam DEBOUNCE_20MS = CLK_50/50.
- One sub-module, btn_debounce: synchronizer, debounce counter and press-event pulse, instantiated three times (start, lap, clr), parameterized by DEBOUNCE_CYC.

Test Plan:
All scenarios use CLK_HZ=20, TICK_HZ=1, DEBOUNCE_CYC=4.
- Debounce: btn_start_n glitches low for 3 cycles -> no event, state stays IDLE. Held low 10 cycles -> exactly one event, state=RUN 6 cycles after the falling edge.
- Rate: in RUN with sw_fast=0 -> tick every 20 cycles. Set sw_fast=1 at prescaler=15 -> tick on the next cycle, then every 10 cycles.
- Pause/resume: press start at prescaler=7 -> no ticks while PAUSE. Resume -> first tick 13 cycles after re-entry to RUN.
- Terminal: dir=0, cnt_max=1 when a tick is due -> tick=0, state=DONE. Start press in DONE -> state stays DONE. Repeat with sw_dir=1 and cnt_zero=1.
- Clear vs start same cycle (in RUN): clr=1 for one cycle, state=IDLE, hold=0, no tick.
- Lap: in RUN, lap press -> hold=1; pause/resume keeps hold=1; second lap -> hold=0. Lap in IDLE -> hold stays 0. Async rst_n low mid-RUN -> all outputs 0 immediately.
